// File: rtl/regfile_sb.sv
// Two-read, two-write register file with a per-register scoreboard of
// pending-write busy bits, write-to-read forwarding and a busy counter.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [ADDR_W-1:0] r_number_a,
   input  logic [ADDR_W-1:0] r_number_b,
   output logic [DATA_W-1:0] data_out_a,
   output logic [DATA_W-1:0] data_out_b,
   output logic              busy_a,
   output logic              busy_b,
   input  logic [ADDR_W-1:0] w_number,
   input  logic [DATA_W-1:0] data_in,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w2_number,
   input  logic [DATA_W-1:0] data2_in,
   input  logic              w2_en,
   input  logic [ADDR_W-1:0] rsv_number,
   input  logic              rsv_en,
   output logic              rsv_ok,
   input  logic              flush,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   busy_cnt_q;
   logic [ADDR_W:0]   busy_cnt_d;

   logic [DEPTH-1:0]  rel;
   logic [DEPTH-1:0]  busy_eff;
   logic              w1_do;
   logic              w2_do;
   logic              rsv_zero;

   // Register 0 is hardwired only when ZERO_REG is set
   assign w1_do    = w_en  && ((ZERO_REG == 0) || (w_number  != '0));
   assign w2_do    = w2_en && ((ZERO_REG == 0) || (w2_number != '0));
   assign rsv_zero = (ZERO_REG != 0) && (rsv_number == '0);

   always_comb begin
      rel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel[i] = (w_en  && (w_number  == ADDR_W'(i)))
               || (w2_en && (w2_number == ADDR_W'(i)));
      end
   end

   assign busy_eff = busy_q & ~rel;

   assign rsv_ok = rsv_en && !clr && !flush
                && !busy_eff[rsv_number] && !rsv_zero;

   function automatic logic [DATA_W-1:0] rd_data(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] arr_val
   );
      logic [DATA_W-1:0] v;
      if ((ZERO_REG != 0) && (addr == '0))
         v = '0;
      else if (w2_en && (w2_number == addr))
         v = data2_in;
      else if (w_en && (w_number == addr))
         v = data_in;
      else
         v = arr_val;
      return v;
   endfunction

   always_comb begin
      data_out_a = rd_data(r_number_a, mem_q[r_number_a]);
      data_out_b = rd_data(r_number_b, mem_q[r_number_b]);
      busy_a     = busy_eff[r_number_a];
      busy_b     = busy_eff[r_number_b];
   end

   // Port 2 is applied last so it wins a same-address conflict
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else begin
         if (w1_do) mem_d[w_number]  = data_in;
         if (w2_do) mem_d[w2_number] = data2_in;
      end
   end

   // A reserve in the same cycle as a release re-arms the bit
   always_comb begin
      busy_d = busy_eff;
      if (clr || flush) begin
         busy_d = '0;
      end else if (rsv_ok) begin
         busy_d[rsv_number] = 1'b1;
      end
   end

   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
   end

   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: reset, scoreboard reserve/release,
// forwarding, dual-write conflict, register 0 and flush.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        clr;
   logic [4:0]  r_number_a, r_number_b;
   logic [31:0] data_out_a, data_out_b;
   logic        busy_a, busy_b;
   logic [4:0]  w_number, w2_number, rsv_number;
   logic [31:0] data_in, data2_in;
   logic        w_en, w2_en, rsv_en, rsv_ok, flush;
   logic [5:0]  busy_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .clk(clk), .clr(clr),
      .r_number_a(r_number_a), .r_number_b(r_number_b),
      .data_out_a(data_out_a), .data_out_b(data_out_b),
      .busy_a(busy_a), .busy_b(busy_b),
      .w_number(w_number), .data_in(data_in), .w_en(w_en),
      .w2_number(w2_number), .data2_in(data2_in), .w2_en(w2_en),
      .rsv_number(rsv_number), .rsv_en(rsv_en), .rsv_ok(rsv_ok),
      .flush(flush), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 0; w_en = 0; w2_en = 0; rsv_en = 0; flush = 0;
   endtask

   initial begin
      idle();
      r_number_a = 0; r_number_b = 0;
      w_number = 0; w2_number = 0; rsv_number = 0;
      data_in = 0; data2_in = 0;
      clr = 1;
      step();
      idle();

      // Scribble some state, then reset
      w_en = 1; w_number = 3; data_in = 32'h1234_5678;
      w2_en = 1; w2_number = 20; data2_in = 32'hCAFE_F00D;
      rsv_en = 1; rsv_number = 6;
      step();
      idle();
      clr = 1; rsv_en = 1; rsv_number = 8;
      w_en = 1; w_number = 8; data_in = 32'h5555_AAAA;
      #1;
      check("rsv_ok_in_clr", rsv_ok, 0);
      step();
      idle();
      #1;
      check("busy_cnt_rst", busy_cnt, 0);
      for (int i = 0; i < 32; i++) begin
         r_number_a = 5'(i);
         r_number_b = 5'(31 - i);
         #1;
         check($sformatf("rst_a%0d", i), data_out_a, 0);
         check($sformatf("rst_b%0d", 31 - i), data_out_b, 0);
         check($sformatf("rst_busy_a%0d", i), busy_a, 0);
         check($sformatf("rst_busy_b%0d", 31 - i), busy_b, 0);
      end

      // Reserve and release r5
      rsv_en = 1; rsv_number = 5;
      #1;
      check("rsv5_ok", rsv_ok, 1);
      step();
      idle();
      r_number_a = 5;
      #1;
      check("busy5", busy_a, 1);
      check("cnt_after_rsv5", busy_cnt, 1);
      w_en = 1; w_number = 5; data_in = 32'hDEAD_BEEF;
      #1;
      check("fwd5", data_out_a, 32'hDEAD_BEEF);
      check("busy5_rel", busy_a, 0);
      step();
      idle();
      #1;
      check("cnt_after_rel5", busy_cnt, 0);
      check("arr5", data_out_a, 32'hDEAD_BEEF);

      // Double reserve of r7
      rsv_en = 1; rsv_number = 7;
      #1;
      check("rsv7_ok", rsv_ok, 1);
      step();
      #1;
      check("rsv7_again", rsv_ok, 0);
      step();
      idle();
      #1;
      check("cnt_dbl7", busy_cnt, 1);

      // Write + re-reserve r7 in one cycle
      w_en = 1; w_number = 7; data_in = 32'h0000_0777;
      rsv_en = 1; rsv_number = 7;
      #1;
      check("rsv7_wr_ok", rsv_ok, 1);
      step();
      idle();
      r_number_a = 7;
      #1;
      check("r7_data", data_out_a, 32'h0000_0777);
      check("r7_busy", busy_a, 1);
      check("cnt_rersv7", busy_cnt, 1);

      // Dual-write conflict on r9
      w_en = 1; w_number = 9; data_in = 32'h11;
      w2_en = 1; w2_number = 9; data2_in = 32'h22;
      r_number_b = 9;
      #1;
      check("conf9_fwd", data_out_b, 32'h22);
      step();
      idle();
      #1;
      check("conf9_arr", data_out_b, 32'h22);
      check("conf9_busy", busy_b, 0);

      // Release via port 2 seen on read port B
      rsv_en = 1; rsv_number = 12;
      step();
      idle();
      r_number_b = 12;
      #1;
      check("busy12", busy_b, 1);
      check("cnt_r12", busy_cnt, 2);
      w2_en = 1; w2_number = 12; data2_in = 32'hABCD_0012;
      #1;
      check("busy12_rel2", busy_b, 0);
      check("fwd12", data_out_b, 32'hABCD_0012);
      step();
      idle();
      #1;
      check("cnt_rel12", busy_cnt, 1);

      // Register 0
      w_en = 1; w_number = 0; data_in = 32'h0000_FFFF;
      r_number_a = 0;
      #1;
      check("r0_fwd", data_out_a, 0);
      step();
      idle();
      #1;
      check("r0_arr", data_out_a, 0);
      rsv_en = 1; rsv_number = 0;
      #1;
      check("rsv0", rsv_ok, 0);
      check("busy0", busy_a, 0);
      step();
      idle();
      #1;
      check("cnt_rsv0", busy_cnt, 1);

      // Release r7, reserve r1..r3, then flush
      w_en = 1; w_number = 7; data_in = 32'h7;
      step();
      idle();
      for (int i = 1; i <= 3; i++) begin
         rsv_en = 1; rsv_number = 5'(i);
         #1;
         check($sformatf("rsv%0d_ok", i), rsv_ok, 1);
         step();
      end
      idle();
      #1;
      check("cnt_three", busy_cnt, 3);
      flush = 1; rsv_en = 1; rsv_number = 4;
      w_en = 1; w_number = 10; data_in = 32'h0000_00AB;
      #1;
      check("rsv4_flush", rsv_ok, 0);
      step();
      idle();
      r_number_a = 2; r_number_b = 10;
      #1;
      check("cnt_flush", busy_cnt, 0);
      check("busy2_flush", busy_a, 0);
      check("r10_flush_wr", data_out_b, 32'h0000_00AB);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule
